writeback_stage: RTL and testbench

- Final pipeline stage; consumes the registered Memory-WriteBack bundle (rd, opcode, write-back data, valid).
- Owns the integer register file: 32 x N, x0 hardwired to zero.
- Provides two combinational read ports to Decode, with same-cycle write-through bypass.
- Also provides a registered retire record (trace and late forwarding) and a 64-bit retired-instruction counter.

---
 rtl/writeback_stage_pkg.sv | 19 +
 rtl/regfile_2r1w.sv | 34 +++
 rtl/writeback_stage.sv | 52 +++++
 tb/tb_writeback_stage.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared opcodes, widths and the rd-write predicate reused by Decode hazard logic
package writeback_stage_pkg;
  localparam int N = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LD     = 7'b0000011;
  localparam logic [6:0] S      = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  function automatic logic writes_rd(input logic [6:0] opcode);
    return opcode inside {OP, OP_IMM, LD, JAL, JALR, LUI, AUIPC};
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read 1-write register file, x0 reads zero, same-cycle write-through bypass
module regfile_2r1w
  import writeback_stage_pkg::*;
#(
  parameter int N          = 32,
  parameter int NUM_REGS   = 32,
  parameter bit RESET_REGS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [N-1:0]          wr_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [N-1:0]          rs1_data,
  output logic [N-1:0]          rs2_data
);
  logic [N-1:0] regs [NUM_REGS];
  logic         wr;
  assign wr = we && wr_addr != '0;
  if (RESET_REGS) begin : g_rst
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (wr) regs[wr_addr] <= wr_data;
  end else begin : g_nrst
    always_ff @(posedge clk)
      if (rst_n && wr) regs[wr_addr] <= wr_data;
  end
  always_comb begin
    rs1_data = rs1_addr == '0 ? '0 : (wr && rs1_addr == wr_addr) ? wr_data : regs[rs1_addr];
    rs2_data = rs2_addr == '0 ? '0 : (wr && rs2_addr == wr_addr) ? wr_data : regs[rs2_addr];
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final stage owning the register file, retire record and instret counter
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int N          = 32,
  parameter int NUM_REGS   = 32,
  parameter bit RESET_REGS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_wb_rd,
  input  logic [6:0]            i_opcode,
  input  logic [N-1:0]          i_wb_data,
  input  logic                  i_mem_vld,
  input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
  input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
  output logic [N-1:0]          o_rs1_data,
  output logic [N-1:0]          o_rs2_data,
  output logic                  o_ret_vld,
  output logic [ADDR_WIDTH-1:0] o_ret_rd,
  output logic [N-1:0]          o_ret_data,
  output logic [6:0]            o_ret_opcode,
  output logic [63:0]           o_instret
);
  logic we;
  assign we = i_mem_vld && i_wb_rd != '0 && writes_rd(i_opcode);
  regfile_2r1w #(.N(N), .NUM_REGS(NUM_REGS), .RESET_REGS(RESET_REGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_addr  (i_wb_rd),
    .wr_data  (i_wb_data),
    .rs1_addr (i_rs1_addr),
    .rs2_addr (i_rs2_addr),
    .rs1_data (o_rs1_data),
    .rs2_data (o_rs2_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_ret_vld    <= 1'b0;
      o_ret_rd     <= '0;
      o_ret_data   <= '0;
      o_ret_opcode <= '0;
      o_instret    <= '0;
    end else begin
      o_ret_vld    <= i_mem_vld;
      o_ret_rd     <= we ? i_wb_rd : '0;
      o_ret_data   <= we ? i_wb_data : '0;
      o_ret_opcode <= i_mem_vld ? i_opcode : '0;
      o_instret    <= o_instret + {63'd0, i_mem_vld};
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with hand-computed expectations for writeback_stage
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr, ret_rd;
  logic [6:0]  opcode, ret_opcode;
  logic [31:0] wb_data, rs1_data, rs2_data, ret_data;
  logic        mem_vld, ret_vld;
  logic [63:0] instret;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_cnt = 0;
  logic [6:0]  ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                            7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111, 7'b1111111};
  logic        wrs [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  always #5 clk = ~clk;
  writeback_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wb_rd      (wb_rd),
    .i_opcode     (opcode),
    .i_wb_data    (wb_data),
    .i_mem_vld    (mem_vld),
    .i_rs1_addr   (rs1_addr),
    .i_rs2_addr   (rs2_addr),
    .o_rs1_data   (rs1_data),
    .o_rs2_data   (rs2_data),
    .o_ret_vld    (ret_vld),
    .o_ret_rd     (ret_rd),
    .o_ret_data   (ret_data),
    .o_ret_opcode (ret_opcode),
    .o_instret    (instret)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [31:0] d);
    mem_vld = v;
    opcode  = op;
    wb_rd   = rd;
    wb_data = d;
    #1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_ret(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic [6:0] op);
    chk({tag, "_vld"}, {63'd0, ret_vld}, {63'd0, v});
    chk({tag, "_rd"}, {59'd0, ret_rd}, {59'd0, rd});
    chk({tag, "_data"}, {32'd0, ret_data}, {32'd0, d});
    chk({tag, "_op"}, {57'd0, ret_opcode}, {57'd0, op});
    chk({tag, "_cnt"}, instret, exp_cnt);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    drive(1'b0, 7'd0, 5'd0, 32'd0);
    #2;
    chk_ret("reset", 1'b0, 5'd0, 32'd0, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(32 - a);
      #1;
      chk("reset_rs1", {32'd0, rs1_data}, 64'd0);
      chk("reset_rs2", {32'd0, rs2_data}, 64'd0);
    end
    step();
    // load into x5 with same-cycle bypass on rs1
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    drive(1'b1, 7'b0000011, 5'd5, 32'hDEADBEEF);
    chk("ld_bypass", {32'd0, rs1_data}, 64'hDEADBEEF);
    chk("ld_x0", {32'd0, rs2_data}, 64'd0);
    step();
    exp_cnt++;
    chk_ret("ld", 1'b1, 5'd5, 32'hDEADBEEF, 7'b0000011);
    drive(1'b0, 7'd0, 5'd0, 32'd0);
    chk("ld_x5", {32'd0, rs1_data}, 64'hDEADBEEF);
    rs1_addr = 5'd0;
    drive(1'b1, 7'b0110011, 5'd0, 32'h1234);
    chk("op_x0_same", {32'd0, rs1_data}, 64'd0);
    step();
    exp_cnt++;
    chk("op_x0_next", {32'd0, rs1_data}, 64'd0);
    chk_ret("op_x0", 1'b1, 5'd0, 32'd0, 7'b0110011);
    drive(1'b1, 7'b0010011, 5'd7, 32'h11);
    step();
    exp_cnt++;
    rs1_addr = 5'd7;
    rs2_addr = 5'd7;
    drive(1'b1, 7'b0100011, 5'd7, 32'h55);
    chk("st_rs1", {32'd0, rs1_data}, 64'h11);
    chk("st_rs2", {32'd0, rs2_data}, 64'h11);
    step();
    exp_cnt++;
    chk_ret("st", 1'b1, 5'd0, 32'd0, 7'b0100011);
    drive(1'b0, 7'd0, 5'd0, 32'd0);
    chk("st_x7", {32'd0, rs1_data}, 64'h11);
    rs1_addr = 5'd9;
    drive(1'b0, 7'b0110011, 5'd9, 32'hAA);
    chk("inv_bypass", {32'd0, rs1_data}, 64'd0);
    step();
    chk_ret("inv", 1'b0, 5'd0, 32'd0, 7'd0);
    chk("inv_x9", {32'd0, rs1_data}, 64'd0);
    // every opcode class, each to its own fresh register
    for (int k = 0; k < 12; k++) begin
      rs1_addr = 5'(10 + k);
      drive(1'b1, ops[k], 5'(10 + k), 32'hA000_0000 + k);
      chk("opc_bypass", {32'd0, rs1_data}, wrs[k] ? 64'hA000_0000 + k : 64'd0);
      step();
      exp_cnt++;
      chk_ret("opc", 1'b1, wrs[k] ? 5'(10 + k) : 5'd0, wrs[k] ? 32'hA000_0000 + k : 32'd0, ops[k]);
      drive(1'b0, 7'd0, 5'd0, 32'd0);
      chk("opc_reg", {32'd0, rs1_data}, wrs[k] ? 64'hA000_0000 + k : 64'd0);
    end
    drive(1'b1, 7'b0110011, 5'd0, 32'd0);
    force dut.o_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.o_instret;
    step();
    chk("wrap", instret, 64'd0);
    step();
    chk("wrap_next", instret, 64'd1);
    drive(1'b1, 7'b0110011, 5'd3, 32'h333);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk_ret("midrst", 1'b0, 5'd0, 32'd0, 7'd0);
    drive(1'b0, 7'd0, 5'd0, 32'd0);
    step();
    rst_n = 1'b1;
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;
    #1;
    chk("midrst_x3", {32'd0, rs1_data}, 64'd0);
    chk("midrst_x5", {32'd0, rs2_data}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
